// File: rtl/dcache_scrub_pkg.sv
//============================================================================
// dcache_scrub_pkg: shared types for the dcache ECC patrol scrubber.
// Rev 1.0
//============================================================================
`default_nettype none

package dcache_scrub_pkg;

  localparam int CE_COUNT_WIDTH   = 16;
  localparam int SCRUB_TAG_WIDTH  = 44;
  localparam int SCRUB_LINE_WIDTH = 128;

  typedef enum logic [1:0] {
    SCRUB_IDLE = 2'd0,
    SCRUB_WAIT = 2'd1,
    SCRUB_READ = 2'd2,
    SCRUB_FIX  = 2'd3
  } scrub_state_e;

  typedef struct packed {
    logic                        valid;
    logic                        dirty;
    logic [SCRUB_TAG_WIDTH-1:0]  tag;
    logic [SCRUB_LINE_WIDTH-1:0] data;
  } scrub_line_t;

endpackage

`default_nettype wire

// File: rtl/dcache_scrub_way_sel.sv
//============================================================================
// dcache_scrub_way_sel: lowest-index pick among ways that are correctable
// and free of uncorrectable errors.  Rev 1.0
//============================================================================
`default_nettype none

module dcache_scrub_way_sel #(
  parameter int NR_WAYS = 8
) (
  input  logic [NR_WAYS-1:0] ce_i,
  input  logic [NR_WAYS-1:0] ue_i,
  output logic               found_o,
  output logic [NR_WAYS-1:0] onehot_o
);

  logic [NR_WAYS-1:0] cand;

  always_comb begin
    cand     = ce_i & ~ue_i;
    found_o  = |cand;
    // Two's-complement trick isolates the least significant set bit.
    onehot_o = cand & (~cand + NR_WAYS'(1));
  end

endmodule

`default_nettype wire

// File: rtl/dcache_ecc_scrubber.sv
//============================================================================
// dcache_ecc_scrubber: background patrol scrubber for the ECC data cache.
// Define DCACHE_SCRUB_UE_LOG_EN for a sticky first-UE log.  Rev 1.0
//============================================================================
`default_nettype none

module dcache_ecc_scrubber
  import dcache_scrub_pkg::*;
#(
  parameter int NR_WAYS        = 8,
  parameter int NUM_SETS       = 256,
  parameter int INDEX_WIDTH    = $clog2(NUM_SETS),
  parameter int LINE_WIDTH     = SCRUB_LINE_WIDTH,
  parameter int TAG_WIDTH      = SCRUB_TAG_WIDTH,
  parameter int INTERVAL_WIDTH = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          enable_i,
  input  logic [INTERVAL_WIDTH-1:0]     interval_i,
  output logic [NR_WAYS-1:0]            req_o,
  input  logic                          gnt_i,
  output logic [INDEX_WIDTH-1:0]        index_o,
  output logic                          we_o,
  output logic [TAG_WIDTH-1:0]          wdata_tag_o,
  output logic [LINE_WIDTH-1:0]         wdata_data_o,
  output logic                          wdata_valid_o,
  output logic                          wdata_dirty_o,
  input  logic [NR_WAYS*TAG_WIDTH-1:0]  rd_tag_i,
  input  logic [NR_WAYS*LINE_WIDTH-1:0] rd_data_i,
  input  logic [NR_WAYS-1:0]            rd_valid_i,
  input  logic [NR_WAYS-1:0]            rd_dirty_i,
  input  logic [NR_WAYS-1:0]            ce_i,
  input  logic [NR_WAYS-1:0]            ue_i,
  output logic                          busy_o,
  output logic                          sweep_done_o,
  output logic [CE_COUNT_WIDTH-1:0]     ce_count_o,
`ifdef DCACHE_SCRUB_UE_LOG_EN
  input  logic                          ue_clear_i,
  output logic                          ue_valid_o,
  output logic [INDEX_WIDTH-1:0]        ue_index_o,
  output logic [NR_WAYS-1:0]            ue_way_o,
`endif
  output logic                          ue_o
);

  scrub_state_e                state_q, state_d;
  logic [INDEX_WIDTH-1:0]      index_q, index_d;
  logic [INTERVAL_WIDTH-1:0]   gap_q, gap_d;
  logic [CE_COUNT_WIDTH-1:0]   ce_count_q, ce_count_d;
  logic                        fix_found;
  logic [NR_WAYS-1:0]          fix_way;
  scrub_line_t                 sel_line, wline;

  dcache_scrub_way_sel #(.NR_WAYS(NR_WAYS)) u_way_sel (
    .ce_i     (ce_i),
    .ue_i     (ue_i),
    .found_o  (fix_found),
    .onehot_o (fix_way)
  );

  always_comb begin
    sel_line = '0;
    for (int w = 0; w < NR_WAYS; w++) begin
      if (fix_way[w]) begin
        sel_line.valid = rd_valid_i[w];
        sel_line.dirty = rd_dirty_i[w];
        sel_line.tag   = rd_tag_i[w*TAG_WIDTH +: TAG_WIDTH];
        sel_line.data  = rd_data_i[w*LINE_WIDTH +: LINE_WIDTH];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    index_d      = index_q;
    gap_d        = gap_q;
    ce_count_d   = ce_count_q;
    req_o        = '0;
    we_o         = 1'b0;
    index_o      = '0;
    wline        = '0;
    sweep_done_o = 1'b0;
    ue_o         = 1'b0;
    busy_o       = (state_q != SCRUB_IDLE);

    case (state_q)
      SCRUB_IDLE: begin
        if (enable_i) begin
          gap_d   = interval_i;
          state_d = (interval_i == '0) ? SCRUB_READ : SCRUB_WAIT;
        end
      end
      SCRUB_WAIT: begin
        gap_d = gap_q - INTERVAL_WIDTH'(1);
        if (!enable_i)                          state_d = SCRUB_IDLE;
        else if (gap_q == INTERVAL_WIDTH'(1))   state_d = SCRUB_READ;
      end
      SCRUB_READ: begin
        req_o   = '1;
        index_o = index_q;
        if (gnt_i)          state_d = SCRUB_FIX;
        else if (!enable_i) state_d = SCRUB_IDLE;
      end
      SCRUB_FIX: begin
        index_o = index_q;
        ue_o    = |ue_i;
        if (fix_found) begin
          // Write back in the data-return cycle; a lost grant forces a re-read.
          req_o = fix_way;
          we_o  = 1'b1;
          wline = sel_line;
          if (gnt_i && (ce_count_q != '1)) ce_count_d = ce_count_q + CE_COUNT_WIDTH'(1);
          state_d = enable_i ? SCRUB_READ : SCRUB_IDLE;
        end else begin
          index_d      = index_q + INDEX_WIDTH'(1);
          sweep_done_o = (index_q == INDEX_WIDTH'(NUM_SETS - 1));
          if (enable_i) begin
            gap_d   = interval_i;
            state_d = (interval_i == '0) ? SCRUB_READ : SCRUB_WAIT;
          end else begin
            state_d = SCRUB_IDLE;
          end
        end
      end
      default: state_d = SCRUB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= SCRUB_IDLE;
      index_q    <= '0;
      gap_q      <= '0;
      ce_count_q <= '0;
    end else begin
      state_q    <= state_d;
      index_q    <= index_d;
      gap_q      <= gap_d;
      ce_count_q <= ce_count_d;
    end
  end

  assign ce_count_o    = ce_count_q;
  assign wdata_tag_o   = wline.tag;
  assign wdata_data_o  = wline.data;
  assign wdata_valid_o = wline.valid;
  assign wdata_dirty_o = wline.dirty;

`ifdef DCACHE_SCRUB_UE_LOG_EN
  logic                   ue_found;
  logic [NR_WAYS-1:0]     ue_low;
  logic                   ue_valid_q, ue_valid_d;
  logic [INDEX_WIDTH-1:0] ue_index_q, ue_index_d;
  logic [NR_WAYS-1:0]     ue_way_q, ue_way_d;

  dcache_scrub_way_sel #(.NR_WAYS(NR_WAYS)) u_ue_sel (
    .ce_i     (ue_i),
    .ue_i     ({NR_WAYS{1'b0}}),
    .found_o  (ue_found),
    .onehot_o (ue_low)
  );

  always_comb begin
    ue_valid_d = ue_valid_q;
    ue_index_d = ue_index_q;
    ue_way_d   = ue_way_q;
    if (ue_clear_i) ue_valid_d = 1'b0;
    // A clear in the same cycle as a new UE lets the new one land.
    if ((state_q == SCRUB_FIX) && ue_found && (!ue_valid_q || ue_clear_i)) begin
      ue_valid_d = 1'b1;
      ue_index_d = index_q;
      ue_way_d   = ue_low;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ue_valid_q <= 1'b0;
      ue_index_q <= '0;
      ue_way_q   <= '0;
    end else begin
      ue_valid_q <= ue_valid_d;
      ue_index_q <= ue_index_d;
      ue_way_q   <= ue_way_d;
    end
  end

  assign ue_valid_o = ue_valid_q;
  assign ue_index_o = ue_index_q;
  assign ue_way_o   = ue_way_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dcache_ecc_scrubber.sv
//============================================================================
// tb_dcache_ecc_scrubber: scoreboard bench with a reactive cache-array model.
// Rev 1.0
//============================================================================
`default_nettype none

module tb_dcache_ecc_scrubber;

  localparam int NW = 8;
  localparam int NS = 4;
  localparam int IW = 2;
  localparam int LW = 128;
  localparam int TW = 44;
  localparam int GW = 16;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic              enable_i = 1'b0;
  logic [GW-1:0]     interval_i = '0;
  logic [NW-1:0]     req_o;
  logic              gnt_i;
  logic [IW-1:0]     index_o;
  logic              we_o;
  logic [TW-1:0]     wdata_tag_o;
  logic [LW-1:0]     wdata_data_o;
  logic              wdata_valid_o, wdata_dirty_o;
  logic [NW*TW-1:0]  rd_tag_i = '0;
  logic [NW*LW-1:0]  rd_data_i = '0;
  logic [NW-1:0]     rd_valid_i = 8'h6D;
  logic [NW-1:0]     rd_dirty_i = 8'hC6;
  logic [NW-1:0]     ce_i = '0, ue_i = '0;
  logic              busy_o, sweep_done_o, ue_o;
  logic [15:0]       ce_count_o;
`ifdef DCACHE_SCRUB_UE_LOG_EN
  logic              ue_clear_i = 1'b0;
  logic              ue_valid_o;
  logic [IW-1:0]     ue_index_o;
  logic [NW-1:0]     ue_way_o;
`endif

  always #5 clk_i = ~clk_i;

  dcache_ecc_scrubber #(.NR_WAYS(NW), .NUM_SETS(NS), .INDEX_WIDTH(IW),
                        .LINE_WIDTH(LW), .TAG_WIDTH(TW), .INTERVAL_WIDTH(GW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(enable_i), .interval_i(interval_i),
    .req_o(req_o), .gnt_i(gnt_i), .index_o(index_o), .we_o(we_o),
    .wdata_tag_o(wdata_tag_o), .wdata_data_o(wdata_data_o),
    .wdata_valid_o(wdata_valid_o), .wdata_dirty_o(wdata_dirty_o),
    .rd_tag_i(rd_tag_i), .rd_data_i(rd_data_i), .rd_valid_i(rd_valid_i),
    .rd_dirty_i(rd_dirty_i), .ce_i(ce_i), .ue_i(ue_i), .busy_o(busy_o),
    .sweep_done_o(sweep_done_o), .ce_count_o(ce_count_o),
`ifdef DCACHE_SCRUB_UE_LOG_EN
    .ue_clear_i(ue_clear_i), .ue_valid_o(ue_valid_o), .ue_index_o(ue_index_o),
    .ue_way_o(ue_way_o),
`endif
    .ue_o(ue_o)
  );

  typedef struct {
    logic [NW-1:0] req;
    logic          we;
    logic [IW-1:0] idx;
    logic          ue;
    logic          sw;
    logic [15:0]   cnt;
    int            gap;
    logic [LW-1:0] data;
    logic [TW-1:0] tag;
    logic          v, d;
  } exp_t;

  exp_t          exp_q[$];
  int            vectors = 0, fails = 0;
  int            cyc = 0, last_ev = 0;
  logic [NW-1:0] err_ce[NS], err_ue[NS];
  int            deny_wr = 0;
  logic          hold_rd = 1'b0;
  logic [IW-1:0] hold_idx = '0;
  logic          rd_pend = 1'b0, wr_denied = 1'b0;
  logic [IW-1:0] rd_idx = '0;

  // Arbiter model: reads granted unless held at hold_idx, writes unless a denial is pending.
  assign gnt_i = (req_o != '0) && (we_o ? (deny_wr == 0) : !(hold_rd && (index_o == hold_idx)));

  function automatic logic [LW-1:0] line_data(input int idx, input int w);
    logic [31:0] word;
    word = {16'hDA7A, 8'(idx), 8'(w)};
    return {word, ~word, word ^ 32'h5A5A_5A5A, word + 32'h1};
  endfunction

  function automatic logic [TW-1:0] line_tag(input int idx, input int w);
    return {12'hA5C, 8'(idx * 3), 16'hBEEF ^ 16'(w * 257), 8'(w)};
  endfunction

  task automatic push(input logic [NW-1:0] req, input logic we, input int idx,
                      input logic ue, input logic sw, input logic [15:0] cnt, input int gap);
    exp_t e;
    int   w;
    logic [NW-1:0] vb, db;
    vb = 8'h6D; db = 8'hC6; w = 0;
    e.req = req; e.we = we; e.idx = IW'(idx); e.ue = ue; e.sw = sw; e.cnt = cnt; e.gap = gap;
    e.data = '0; e.tag = '0; e.v = 1'b0; e.d = 1'b0;
    if (we) begin
      for (int i = 0; i < NW; i++) if (req[i]) w = i;
      e.data = line_data(idx, w); e.tag = line_tag(idx, w); e.v = vb[w]; e.d = db[w];
    end
    exp_q.push_back(e);
  endtask

  task automatic rd(input int idx, input logic [15:0] cnt, input int gap);
    push(8'hFF, 1'b0, idx, 1'b0, 1'b0, cnt, gap);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: every cycle with a request or a pulse is one scored event.
  always @(negedge clk_i) begin
    exp_t e;
    cyc++;
    if (!rst_ni) begin
      rd_pend = 1'b0; wr_denied = 1'b0;
    end else begin
      if ((req_o != '0) || ue_o || sweep_done_o) begin
        vectors++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_event req=%h we=%b idx=%0d ue=%b sw=%b cnt=%h",
                   req_o, we_o, index_o, ue_o, sweep_done_o, ce_count_o);
        end else begin
          e = exp_q.pop_front();
          if ({req_o, we_o, index_o, ue_o, sweep_done_o, ce_count_o} !== {e.req, e.we, e.idx, e.ue, e.sw, e.cnt}
              || {wdata_data_o, wdata_tag_o, wdata_valid_o, wdata_dirty_o} !== {e.data, e.tag, e.v, e.d}
              || (e.gap >= 0 && (cyc - last_ev) != e.gap)) begin
            fails++;
            $display("FAIL event actual req=%h we=%b idx=%0d ue=%b sw=%b cnt=%h gap=%0d data=%h tag=%h v=%b d=%b required req=%h we=%b idx=%0d ue=%b sw=%b cnt=%h gap=%0d data=%h tag=%h v=%b d=%b",
                     req_o, we_o, index_o, ue_o, sweep_done_o, ce_count_o, cyc - last_ev,
                     wdata_data_o, wdata_tag_o, wdata_valid_o, wdata_dirty_o,
                     e.req, e.we, e.idx, e.ue, e.sw, e.cnt, e.gap, e.data, e.tag, e.v, e.d);
          end
        end
        last_ev = cyc;
      end
      rd_pend   = (req_o == 8'hFF) && !we_o && gnt_i;
      if (rd_pend) rd_idx = index_o;
      wr_denied = we_o && !gnt_i;
      if (we_o && gnt_i) err_ce[index_o] = err_ce[index_o] & ~req_o;
    end
  end

  // Array model: decoded data and error flags appear the cycle after a read grant.
  always begin
    @(posedge clk_i);
    #1;
    if (wr_denied && deny_wr > 0) deny_wr--;
    if (rd_pend) begin
      for (int w = 0; w < NW; w++) begin
        rd_data_i[w*LW +: LW] = line_data(int'(rd_idx), w);
        rd_tag_i[w*TW +: TW]  = line_tag(int'(rd_idx), w);
      end
      ce_i = err_ce[rd_idx];
      ue_i = err_ue[rd_idx];
    end else begin
      ce_i = '0;
      ue_i = '0;
    end
  end

  task automatic do_reset();
    enable_i = 1'b0;
    rst_ni   = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    for (int i = 0; i < NS; i++) begin err_ce[i] = '0; err_ue[i] = '0; end
    deny_wr = 0; hold_rd = 1'b0;
    rst_ni  = 1'b1;
  endtask

  task automatic wait_size(input string name, input int n, input int budget);
    int k;
    k = 0;
    while (exp_q.size() > n && k < budget) begin
      @(posedge clk_i);
      #1;
      k++;
    end
    if (exp_q.size() > n) begin
      vectors++; fails++;
      $display("FAIL %s_timeout actual=%0d_pending required=%0d", name, exp_q.size(), n);
      exp_q.delete();
    end
  endtask

  task automatic finish_scn(input string name);
    enable_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    chk({name, "_idle_busy"}, 64'(busy_o), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    do_reset();
    chk("rst_req", 64'(req_o), 64'd0);
    chk("rst_we", 64'(we_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_index", 64'(index_o), 64'd0);
    chk("rst_count", 64'(ce_count_o), 64'd0);
    chk("rst_pulses", 64'({ue_o, sweep_done_o}), 64'd0);
    chk("rst_wdata", 64'({|wdata_data_o, |wdata_tag_o, wdata_valid_o, wdata_dirty_o}), 64'd0);

    // Clean sweep, interval 2: reads spaced FIX + 2 WAIT + READ apart.
    interval_i = 16'd2;
    rd(0, 16'd0, -1); rd(1, 16'd0, 4); rd(2, 16'd0, 4); rd(3, 16'd0, 4);
    push(8'h00, 1'b0, 3, 1'b0, 1'b1, 16'd0, 1);
    enable_i = 1'b1;
    wait_size("clean", 0, 200);
    finish_scn("clean");

    // Single CE on way 2 of set 1.
    do_reset();
    err_ce[1] = 8'h04; interval_i = '0;
    rd(0, 16'd0, -1); rd(1, 16'd0, 2);
    push(8'h04, 1'b1, 1, 1'b0, 1'b0, 16'd0, 1);
    rd(1, 16'd1, 1); rd(2, 16'd1, 2);
    enable_i = 1'b1;
    wait_size("single_ce", 0, 200);
    finish_scn("single_ce");
    chk("single_ce_count", 64'(ce_count_o), 64'd1);

    // First write grant denied: re-read, then write without counting the loss.
    do_reset();
    err_ce[0] = 8'h10; deny_wr = 1; interval_i = '0;
    rd(0, 16'd0, -1);
    push(8'h10, 1'b1, 0, 1'b0, 1'b0, 16'd0, 1);
    rd(0, 16'd0, 1);
    push(8'h10, 1'b1, 0, 1'b0, 1'b0, 16'd0, 1);
    rd(0, 16'd1, 1); rd(1, 16'd1, 2);
    enable_i = 1'b1;
    wait_size("deny", 0, 200);
    finish_scn("deny");
    chk("deny_count", 64'(ce_count_o), 64'd1);

    // CE on ways 0 and 7 with UE on way 0: only way 7 written, UE pulses twice.
    do_reset();
    err_ce[1] = 8'h81; err_ue[1] = 8'h01; interval_i = '0;
    rd(0, 16'd0, -1); rd(1, 16'd0, 2);
    push(8'h80, 1'b1, 1, 1'b1, 1'b0, 16'd0, 1);
    rd(1, 16'd1, 1);
    push(8'h00, 1'b0, 1, 1'b1, 1'b0, 16'd1, 1);
    rd(2, 16'd1, 1);
    enable_i = 1'b1;
    wait_size("ue", 0, 200);
    finish_scn("ue");
`ifdef DCACHE_SCRUB_UE_LOG_EN
    chk("ue_log_valid", 64'(ue_valid_o), 64'd1);
    chk("ue_log_index", 64'(ue_index_o), 64'd1);
    chk("ue_log_way", 64'(ue_way_o), 64'h01);
    ue_clear_i = 1'b1;
    @(posedge clk_i); #1;
    ue_clear_i = 1'b0;
    chk("ue_log_cleared", 64'(ue_valid_o), 64'd0);
`endif

    // Enable drops while the read at set 1 is ungranted; resume at set 1.
    do_reset();
    hold_idx = 2'd1; hold_rd = 1'b1; interval_i = '0;
    rd(0, 16'd0, -1); rd(1, 16'd0, 2); rd(1, 16'd0, 1); rd(1, 16'd0, 1);
    enable_i = 1'b1;
    wait_size("drop", 1, 200);
    enable_i = 1'b0;
    @(posedge clk_i); #1;
    chk("drop_busy", 64'(busy_o), 64'd0);
    chk("drop_pending", 64'(exp_q.size()), 64'd0);
    hold_rd = 1'b0;
    rd(1, 16'd0, -1); rd(2, 16'd0, 2);
    enable_i = 1'b1;
    wait_size("resume", 0, 200);
    finish_scn("resume");

    // Saturation: counter preset to FFFE, three CEs in set 0.
    do_reset();
    force dut.ce_count_q = 16'hFFFE;
    @(posedge clk_i); #1;
    release dut.ce_count_q;
    chk("sat_preload", 64'(ce_count_o), 64'hFFFE);
    err_ce[0] = 8'h07; interval_i = '0;
    rd(0, 16'hFFFE, -1);
    push(8'h01, 1'b1, 0, 1'b0, 1'b0, 16'hFFFE, 1);
    rd(0, 16'hFFFF, 1);
    push(8'h02, 1'b1, 0, 1'b0, 1'b0, 16'hFFFF, 1);
    rd(0, 16'hFFFF, 1);
    push(8'h04, 1'b1, 0, 1'b0, 1'b0, 16'hFFFF, 1);
    rd(0, 16'hFFFF, 1); rd(1, 16'hFFFF, 2);
    enable_i = 1'b1;
    wait_size("sat", 0, 200);
    finish_scn("sat");
    chk("sat_count", 64'(ce_count_o), 64'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

`default_nettype wire
